// File: rtl/range_sweeper.sv
// Sweeps inclusive ID ranges into an external checker and sums the IDs it flags.
// Candidates in flight are held in a small in-order FIFO until their verdict returns.
module range_sweeper #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned LONG_DATA_WIDTH = 48,
  parameter int unsigned DEPTH           = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       range_valid,
  output logic                       range_ready,
  input  logic [DATA_WIDTH-1:0]      range_lo,
  input  logic [DATA_WIDTH-1:0]      range_hi,
  input  logic                       range_last,
  output logic [DATA_WIDTH-1:0]      n_out,
  output logic                       n_valid,
  input  logic                       n_ready,
  input  logic                       chk_valid,
  input  logic                       chk_match,
  output logic [LONG_DATA_WIDTH-1:0] sum_out,
  output logic                       busy,
  output logic                       done,
  output logic                       protocol_err
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] cur, hi_r;
  logic                  last_r;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  fifo_full, fifo_empty;
  logic                  accept, push, pop;

  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign fifo_empty = (count == CNT_W'(0));
  assign pop        = chk_valid && !fifo_empty;
  assign n_out      = cur;
  assign busy       = (state == SWEEP) || (state == DRAIN) || !fifo_empty;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and handshake decode
  always_comb begin
    state_nxt   = state;
    range_ready = 1'b0;
    n_valid     = 1'b0;
    done        = 1'b0;
    accept      = 1'b0;
    push        = 1'b0;
    case (state)
      IDLE: begin
        range_ready = 1'b1;
        if (range_valid) begin
          accept = 1'b1;
          if (range_lo > range_hi) state_nxt = range_last ? DRAIN : IDLE;
          else                     state_nxt = SWEEP;
        end
      end
      SWEEP: begin
        n_valid = !fifo_full;
        push    = n_valid && n_ready;
        // Equality stop keeps a range ending at the top ID from wrapping
        if (push && (cur == hi_r)) state_nxt = last_r ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (fifo_empty) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // Sweep cursor, FIFO bookkeeping, accumulator and error flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur          <= '0;
      hi_r         <= '0;
      last_r       <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      sum_out      <= '0;
      protocol_err <= 1'b0;
    end else if (clear) begin
      cur          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      sum_out      <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (accept) begin
        cur    <= range_lo;
        hi_r   <= range_hi;
        last_r <= range_last;
      end else if (push && (cur != hi_r)) begin
        cur <= cur + DATA_WIDTH'(1);
      end
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
        if (chk_match) sum_out <= sum_out + LONG_DATA_WIDTH'(mem[rd_ptr]);
      end
      if (chk_valid && fifo_empty) protocol_err <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Candidate storage; contents are don't-care while the FIFO is empty
  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr] <= cur;
  end

endmodule

// File: tb/tb_range_sweeper.sv
// Directed and randomized bench for range_sweeper with an in-order checker model
// and a reference built from the range list by plain enumeration.
module tb_range_sweeper;

  localparam int unsigned DW    = 16;
  localparam int unsigned LW    = 48;
  localparam int unsigned DEPTH = 4;

  logic          clock, reset_n, clear;
  logic          range_valid, range_ready, range_last;
  logic [DW-1:0] range_lo, range_hi, n_out;
  logic          n_valid, n_ready, chk_valid, chk_match;
  logic [LW-1:0] sum_out;
  logic          busy, done, protocol_err;

  range_sweeper #(.DATA_WIDTH(DW), .LONG_DATA_WIDTH(LW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear),
    .range_valid(range_valid), .range_ready(range_ready),
    .range_lo(range_lo), .range_hi(range_hi), .range_last(range_last),
    .n_out(n_out), .n_valid(n_valid), .n_ready(n_ready),
    .chk_valid(chk_valid), .chk_match(chk_match),
    .sum_out(sum_out), .busy(busy), .done(done), .protocol_err(protocol_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    longint unsigned lo;
    longint unsigned hi;
    bit              last;
  } rng_t;

  typedef struct {
    logic [DW-1:0] id;
    int            due;
  } pend_t;

  int              n_asserts = 0;
  int              n_fail    = 0;
  int              cyc       = 0;
  int              lat       = 1;
  int              ready_pct = 100;
  int              emitted   = 0;
  int              exp_total = 0;
  longint unsigned exp_sum   = 0;
  longint unsigned exp_ids [$];
  pend_t           pend    [$];
  rng_t            rq      [$];
  logic            prev_stall;
  logic [DW-1:0]   prev_n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Repeated-group ID: even digit count, upper half equals lower half
  function automatic bit halves_eq(input longint unsigned v);
    longint unsigned t = v;
    longint unsigned p = 1;
    int d = 0;
    if (v == 0) return 1'b0;
    while (t > 0) begin
      t = t / 10;
      d++;
    end
    if ((d % 2) != 0) return 1'b0;
    for (int i = 0; i < d / 2; i++) p = p * 10;
    return (v / p) == (v % p);
  endfunction

  task automatic start_test(input int l, input int pct);
    lat        = l;
    ready_pct  = pct;
    exp_sum    = 0;
    exp_total  = 0;
    emitted    = 0;
    prev_stall = 1'b0;
    exp_ids.delete();
    pend.delete();
    rq.delete();
  endtask

  task automatic add_range(input longint unsigned lo, input longint unsigned hi, input bit last);
    rng_t r;
    r.lo = lo; r.hi = hi; r.last = last;
    rq.push_back(r);
    if (lo <= hi) begin
      for (longint unsigned v = lo; v <= hi; v++) begin
        exp_ids.push_back(v);
        exp_total++;
        if (halves_eq(v)) exp_sum += v;
      end
    end
  endtask

  // One clock: drive inputs after a falling edge, account for the handshakes, advance
  task automatic cycle();
    bit take_range;
    range_valid = 1'b0;
    take_range  = 1'b0;
    if (rq.size() > 0 && range_ready) begin
      range_valid = 1'b1;
      range_lo    = DW'(rq[0].lo);
      range_hi    = DW'(rq[0].hi);
      range_last  = rq[0].last;
      take_range  = 1'b1;
    end
    n_ready = ($urandom_range(99) < 32'(ready_pct));
    if (prev_stall) begin
      chk("stall_valid", 64'(n_valid), 64'd1);
      chk("stall_n_out", 64'(n_out), 64'(prev_n));
    end
    if (pend.size() >= DEPTH) chk("full_blocks_valid", 64'(n_valid), 64'd0);
    chk_valid = 1'b0;
    chk_match = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      chk_valid = 1'b1;
      chk_match = halves_eq(64'(pend[0].id));
      void'(pend.pop_front());
    end
    if (n_valid && n_ready) begin
      pend_t p;
      n_asserts++;
      assert (exp_ids.size() > 0) else begin
        n_fail++;
        $error("FAIL extra_candidate: observed n_out=%0d expected none", n_out);
      end
      if (exp_ids.size() > 0) chk("n_out_order", 64'(n_out), exp_ids.pop_front());
      p.id  = n_out;
      p.due = cyc + lat;
      pend.push_back(p);
      emitted++;
    end
    prev_stall = n_valid && !n_ready;
    prev_n     = n_out;
    if (take_range) void'(rq.pop_front());
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic run_to_done(input int budget);
    int c = 0;
    while (!(done && rq.size() == 0 && pend.size() == 0) && c < budget) begin
      cycle();
      c++;
    end
    chk("within_budget", 64'(c < budget), 64'd1);
    chk("done", 64'(done), 64'd1);
    chk("all_candidates", 64'(emitted), 64'(exp_total));
    chk("sum_model", 64'(sum_out), exp_sum & ((64'd1 << LW) - 64'd1));
    chk("no_protocol_err", 64'(protocol_err), 64'd0);
  endtask

  task automatic do_clear();
    range_valid = 1'b0;
    n_ready     = 1'b0;
    chk_valid   = 1'b0;
    clear       = 1'b1;
    @(posedge clock);
    @(negedge clock);
    cyc++;
    clear = 1'b0;
    chk("clear_sum", 64'(sum_out), 64'd0);
    chk("clear_done", 64'(done), 64'd0);
    chk("clear_ready", 64'(range_ready), 64'd1);
    chk("clear_perr", 64'(protocol_err), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    clear       = 1'b0;
    range_valid = 1'b0;
    range_lo    = '0;
    range_hi    = '0;
    range_last  = 1'b0;
    n_ready     = 1'b0;
    chk_valid   = 1'b0;
    chk_match   = 1'b0;
    prev_stall  = 1'b0;
    prev_n      = '0;
    #12;
    chk("rst_ready", 64'(range_ready), 64'd1);
    chk("rst_n_valid", 64'(n_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_perr", 64'(protocol_err), 64'd0);
    chk("rst_sum", 64'(sum_out), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Single range, always-ready checker with one-cycle verdict
    start_test(1, 100);
    add_range(11, 22, 1'b1);
    run_to_done(200);
    chk("r019_count", 64'(emitted), 64'd12);
    chk("r019_sum", 64'(sum_out), 64'd33);

    // Two back-to-back ranges
    do_clear();
    start_test(1, 100);
    add_range(95, 115, 1'b0);
    add_range(998, 1012, 1'b1);
    run_to_done(300);
    chk("r020_count", 64'(emitted), 64'd36);
    chk("r020_sum", 64'(sum_out), 64'd1109);

    // Stalling consumer and long checker latency
    do_clear();
    start_test(6, 50);
    add_range(11, 22, 1'b1);
    run_to_done(500);
    chk("r021_sum", 64'(sum_out), 64'd33);

    // Empty final range
    do_clear();
    start_test(1, 100);
    add_range(30, 20, 1'b1);
    for (int i = 0; i < 3 && !done; i++) cycle();
    chk("empty_done", 64'(done), 64'd1);
    chk("empty_count", 64'(emitted), 64'd0);
    chk("empty_sum", 64'(sum_out), 64'd0);

    // Range ending at the largest ID must not wrap
    do_clear();
    start_test(1, 100);
    add_range((64'd1 << DW) - 3, (64'd1 << DW) - 1, 1'b1);
    run_to_done(100);
    chk("top_count", 64'(emitted), 64'd3);
    for (int i = 0; i < 5; i++) cycle();
    chk("top_no_wrap", 64'(n_valid), 64'd0);
    chk("top_sum_held", 64'(sum_out), 64'd0);
    chk("top_still_done", 64'(done), 64'd1);

    // Restart from DONE
    do_clear();
    start_test(1, 100);
    add_range(22, 22, 1'b1);
    run_to_done(50);
    chk("r024_sum", 64'(sum_out), 64'd22);

    // Randomized range sets, checker latencies and consumer duty cycles
    for (int r = 0; r < 4; r++) begin
      int nr;
      do_clear();
      start_test(int'($urandom_range(1, 8)), int'($urandom_range(30, 100)));
      nr = int'($urandom_range(1, 4));
      for (int k = 0; k < nr; k++) begin
        longint unsigned lo = 64'($urandom_range(1, 3000));
        longint unsigned hi = lo + 64'($urandom_range(0, 40));
        if ($urandom_range(0, 5) == 0) hi = lo - 1;
        add_range(lo, hi, k == nr - 1);
      end
      run_to_done(5000);
    end

    // Asynchronous reset in the middle of a sweep
    do_clear();
    start_test(3, 100);
    add_range(11, 22, 1'b1);
    for (int i = 0; i < 5; i++) cycle();
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(range_ready), 64'd1);
    chk("mid_rst_n_valid", 64'(n_valid), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_perr", 64'(protocol_err), 64'd0);
    chk("mid_rst_sum", 64'(sum_out), 64'd0);
    @(negedge clock);
    reset_n   = 1'b1;
    pend.delete();
    n_ready   = 1'b0;
    chk_valid = 1'b1;
    chk_match = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk_valid = 1'b0;
    chk_match = 1'b0;
    chk("orphan_perr", 64'(protocol_err), 64'd1);
    chk("orphan_sum", 64'(sum_out), 64'd0);
    @(posedge clock);
    @(negedge clock);
    chk("perr_sticky", 64'(protocol_err), 64'd1);
    do_clear();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
